tick_uart_tx: RTL and testbench

Serial transmitter paced by the one-cycle `tick` pulse from the 5-bit prescaler, which ticks once every 31 `clk` cycles when enabled. It accepts a parallel byte with a start strobe and shifts out a UART-style frame: start bit, data LSB first, optional parity, and stop bit(s). It sits downstream of the prescaler and drives the board's serial TX pin.

---
 rtl/tick_uart_tx.sv | 149 ++++++++++++++
 tb/tb_tick_uart_tx.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_uart_tx.sv
// Tick-paced UART transmitter: start bit, LSB-first data, optional parity,
// one or two stop bits. All outputs are registered.
module tick_uart_tx #(
   parameter int DATA_BITS     = 8,
   parameter int TICKS_PER_BIT = 1,
   parameter int PARITY_EN     = 0,
   parameter int PARITY_ODD    = 0,
   parameter int STOP_BITS     = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tick,
   input  logic                 start,
   input  logic [DATA_BITS-1:0] data,
   output logic                 tx,
   output logic                 busy,
   output logic                 done
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   localparam logic [3:0] T_LAST = 4'(TICKS_PER_BIT - 1);
   localparam logic [2:0] D_LAST = 3'(DATA_BITS - 1);
   localparam logic [2:0] P_LAST = 3'(STOP_BITS - 1);
   localparam logic       P_INV  = (PARITY_ODD != 0);
   localparam logic       P_EN   = (PARITY_EN != 0);

   logic [2:0]           state_q, state_d;
   logic [3:0]           tick_cnt_q, tick_cnt_d;
   logic [2:0]           bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 tx_q, tx_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 bit_end;

   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      par_d      = par_q;
      tx_d       = tx_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      bit_end    = tick && (tick_cnt_q == T_LAST);

      if (state_q != S_IDLE && tick) begin
         tick_cnt_d = bit_end ? 4'd0 : tick_cnt_q + 4'd1;
      end

      case (state_q)
         S_IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (start) begin
               // parity taken from the captured byte, never the live input
               shift_d    = data;
               par_d      = (^data) ^ P_INV;
               state_d    = S_START;
               tx_d       = 1'b0;
               busy_d     = 1'b1;
               tick_cnt_d = 4'd0;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d   = S_DATA;
               tx_d      = shift_q[0];
               bit_cnt_d = 3'd0;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (bit_cnt_q == D_LAST) begin
                  bit_cnt_d = 3'd0;
                  if (P_EN) begin
                     state_d = S_PARITY;
                     tx_d    = par_q;
                  end else begin
                     state_d = S_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  shift_d   = shift_q >> 1;
                  tx_d      = shift_q[1];
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               state_d   = S_STOP;
               tx_d      = 1'b1;
               bit_cnt_d = 3'd0;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               if (bit_cnt_q == P_LAST) begin
                  state_d = S_IDLE;
                  tx_d    = 1'b1;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         tick_cnt_q <= 4'd0;
         bit_cnt_q  <= 3'd0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign tx   = tx_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_tick_uart_tx.sv
// Bench for tick_uart_tx: four parameter sets checked every cycle against
// a frame-level model, plus literal expectations for the directed cases.
module tb_tick_uart_tx;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tick = 1'b0;
   logic [3:0] start = 4'b0;
   logic [7:0] data [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
   logic [3:0] tx, busy, done;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int tph = 0;

   // dut0 defaults, dut1 even parity, dut2 odd parity, dut3 4x/2 stop
   int m_tpb [4] = '{1, 1, 1, 4};
   int m_pe  [4] = '{0, 1, 1, 0};
   int m_po  [4] = '{0, 0, 1, 0};
   int m_sb  [4] = '{1, 1, 1, 2};

   tick_uart_tx u_def (
      .clk(clk), .reset(reset), .tick(tick), .start(start[0]),
      .data(data[0]), .tx(tx[0]), .busy(busy[0]), .done(done[0]));
   tick_uart_tx #(.PARITY_EN(1), .PARITY_ODD(0)) u_pe (
      .clk(clk), .reset(reset), .tick(tick), .start(start[1]),
      .data(data[1]), .tx(tx[1]), .busy(busy[1]), .done(done[1]));
   tick_uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) u_po (
      .clk(clk), .reset(reset), .tick(tick), .start(start[2]),
      .data(data[2]), .tx(tx[2]), .busy(busy[2]), .done(done[2]));
   tick_uart_tx #(.TICKS_PER_BIT(4), .STOP_BITS(2)) u_os (
      .clk(clk), .reset(reset), .tick(tick), .start(start[3]),
      .data(data[3]), .tx(tx[3]), .busy(busy[3]), .done(done[3]));

   always #5 clk = ~clk;

   // prescaler stand-in: one-cycle pulse every 31 clocks
   always @(negedge clk) begin
      tph  = (tph == 30) ? 0 : tph + 1;
      tick = (tph == 30);
   end

   // frame model: a list of line levels, each held for TPB ticks
   logic       mb [4][16];
   int         mn [4];
   int         mt [4];
   bit         mact [4];
   logic [3:0] etx = 4'hF, ebusy = 4'h0, edone = 4'h0;
   bit         chk_en = 1'b0;

   logic       lg [4][64];
   int         lg_n [4] = '{0, 0, 0, 0};
   int         chg [4][16];
   int         chg_n [4] = '{0, 0, 0, 0};
   int         done_cyc [4] = '{0, 0, 0, 0};
   int         done_cnt [4] = '{0, 0, 0, 0};
   int         rise_cyc [4] = '{0, 0, 0, 0};
   logic [3:0] pbusy = 4'h0, ptx = 4'hF;

   task automatic model_step(int g, logic r, logic t, logic s,
                             logic [7:0] d);
      int n;
      edone[g] = 1'b0;
      if (r) begin
         mact[g]  = 1'b0;
         etx[g]   = 1'b1;
         ebusy[g] = 1'b0;
      end else if (!mact[g]) begin
         if (s) begin
            n = 0;
            mb[g][n] = 1'b0; n++;
            for (int i = 0; i < 8; i++) begin
               mb[g][n] = d[i]; n++;
            end
            if (m_pe[g] != 0) begin
               mb[g][n] = (^d) ^ (m_po[g] != 0); n++;
            end
            for (int k = 0; k < m_sb[g]; k++) begin
               mb[g][n] = 1'b1; n++;
            end
            mn[g]    = n;
            mt[g]    = 0;
            mact[g]  = 1'b1;
            etx[g]   = 1'b0;
            ebusy[g] = 1'b1;
         end else begin
            etx[g]   = 1'b1;
            ebusy[g] = 1'b0;
         end
      end else if (t) begin
         mt[g]++;
         if (mt[g] == mn[g] * m_tpb[g]) begin
            mact[g]  = 1'b0;
            etx[g]   = 1'b1;
            ebusy[g] = 1'b0;
            edone[g] = 1'b1;
         end else begin
            etx[g] = mb[g][mt[g] / m_tpb[g]];
         end
      end
   endtask

   always @(posedge clk) begin : cmp
      logic       r, t;
      logic [3:0] s;
      logic [7:0] d [4];
      cyc++;
      r = reset;
      t = tick;
      s = start;
      for (int g = 0; g < 4; g++) d[g] = data[g];
      if (r) chk_en = 1'b1;
      for (int g = 0; g < 4; g++) model_step(g, r, t, s[g], d[g]);
      #1;
      if (chk_en) begin
         for (int g = 0; g < 4; g++) begin
            checks++;
            if ({tx[g], busy[g], done[g]} !==
                {etx[g], ebusy[g], edone[g]}) begin
               failures++;
               $display("FAIL cycle dut%0d cyc=%0d got tx,busy,done=%b%b%b want %b%b%b",
                        g, cyc, tx[g], busy[g], done[g],
                        etx[g], ebusy[g], edone[g]);
            end
            if (busy[g] === 1'b1 && pbusy[g] !== 1'b1) begin
               lg_n[g]     = 0;
               chg_n[g]    = 0;
               done_cnt[g] = 0;
               rise_cyc[g] = cyc;
               lg[g][0]    = tx[g];
               lg_n[g]     = 1;
            end else if (busy[g] === 1'b1 && t && lg_n[g] < 64) begin
               lg[g][lg_n[g]] = tx[g];
               lg_n[g]++;
            end
            if (busy[g] === 1'b1 && tx[g] !== ptx[g] && chg_n[g] < 16) begin
               chg[g][chg_n[g]] = cyc;
               chg_n[g]++;
            end
            if (done[g] === 1'b1) begin
               done_cnt[g]++;
               done_cyc[g] = cyc;
            end
            pbusy[g] = busy[g];
            ptx[g]   = tx[g];
         end
      end
   end

   task automatic chk(string nm, int act, int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got %0d want %0d", nm, act, exp);
      end
   endtask

   function automatic int pack(int g);
      int v = 0;
      for (int i = 0; i < lg_n[g] && i < 31; i++)
         if (lg[g][i] === 1'b1) v = v | (1 << i);
      return v;
   endfunction

   task automatic go(int g, logic [7:0] d);
      @(negedge clk);
      start[g] = 1'b1;
      data[g]  = d;
      @(negedge clk);
      start[g] = 1'b0;
   endtask

   task automatic wait_done(int g, int lim);
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (done[g] !== 1'b1 && k < lim);
      checks++;
      if (done[g] !== 1'b1) begin
         failures++;
         $display("FAIL timeout dut%0d got no done want done", g);
      end
   endtask

   initial begin
      int d1, k;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (500) @(negedge clk);
      chk("idle_tx", int'(tx), 15);
      chk("idle_busy", int'(busy), 0);
      chk("idle_done", int'(done), 0);

      go(0, 8'hA5);
      wait_done(0, 600);
      chk("a5_len", lg_n[0], 10);
      chk("a5_bits", pack(0), 'h34A);
      chk("a5_period", chg[0][2] - chg[0][1], 31);
      chk("a5_done_cnt", done_cnt[0], 1);

      go(1, 8'hA5);
      go(2, 8'hA5);
      wait_done(2, 600);
      repeat (2) @(negedge clk);
      chk("even_len", lg_n[1], 11);
      chk("even_bits", pack(1), 'h54A);
      chk("odd_bits", pack(2), 'h74A);
      chk("odd_par", int'(lg[2][9]), 1);
      chk("even_done_cnt", done_cnt[1], 1);

      go(3, 8'h3C);
      wait_done(3, 2000);
      chk("os_len", lg_n[3], 44);
      chk("os_chg_n", chg_n[3], 4);
      chk("os_4bits", chg[3][2] - chg[3][1], 496);
      chk("os_stop", done_cyc[3] - chg[3][3], 248);

      go(0, 8'h0F);
      repeat (93) @(negedge clk);
      start[0] = 1'b1;
      data[0]  = 8'hAA;
      @(negedge clk);
      start[0] = 1'b0;
      wait_done(0, 600);
      chk("ign_bits", pack(0), 'h21E);
      chk("ign_done_cnt", done_cnt[0], 1);

      @(negedge clk);
      start[0] = 1'b1;
      data[0]  = 8'hA5;
      @(negedge clk);
      data[0] = 8'hF0;
      wait_done(0, 600);
      chk("b2b_first", pack(0), 'h34A);
      d1 = done_cyc[0];
      @(negedge clk);
      start[0] = 1'b0;
      wait_done(0, 600);
      chk("b2b_gap", rise_cyc[0] - d1, 1);
      chk("b2b_second", pack(0), 'h3E0);

      go(0, 8'hC3);
      k = 0;
      while (lg_n[0] < 5 && k < 600) begin
         @(negedge clk);
         k++;
      end
      chk("rst_reached_d3", int'(lg_n[0] >= 5), 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_tx", int'(tx[0]), 1);
      chk("rst_busy", int'(busy[0]), 0);
      chk("rst_done", int'(done[0]), 0);
      repeat (400) @(negedge clk);
      chk("rst_no_done", done_cnt[0], 0);
      go(0, 8'h55);
      wait_done(0, 600);
      chk("rst_new_bits", pack(0), 'h2AA);
      chk("rst_new_done", done_cnt[0], 1);

      for (int n = 0; n < 20000; n++) begin
         @(negedge clk);
         reset = ($urandom_range(0, 3999) == 0);
         for (int g = 0; g < 4; g++) begin
            start[g] = ($urandom_range(0, 99) < 3);
            data[g]  = 8'($urandom);
         end
      end
      @(negedge clk);
      reset = 1'b0;
      start = 4'b0;
      repeat (1500) @(negedge clk);
      chk("final_busy", int'(busy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
